// File: rtl/exu_lsu_ost_pkg.sv
// ---------------------------------------------------------------------------
// exu_lsu_pkg
// Shared definitions for the execute-stage load/store unit:
//   - OST tracking entry (lsu_ost_t) pushed at request and popped at response
//   - RV32I LOAD/STORE opcode and funct3 encodings
//   - base byte strobes for byte/half/word stores
//   - immediate decoders (I-type for loads, S-type for stores)
// ---------------------------------------------------------------------------
package exu_lsu_pkg;

    localparam int OST_GPR_AW = 5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_e;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef struct packed {
        logic                  is_ld;
        logic [2:0]            funct3;
        logic [OST_GPR_AW-1:0] rd;
        logic [1:0]            lo;
    } lsu_ost_t;

    function automatic logic [11:0] i_imm_decode(input logic [31:0] ins);
        return ins[31:20];
    endfunction

    function automatic logic [11:0] s_imm_decode(input logic [31:0] ins);
        return {ins[31:25], ins[11:7]};
    endfunction

    // Size field funct3[1:0] selects the unshifted strobe; size 3 is not a
    // legal RV32I store and yields no bytes.
    function automatic logic [3:0] base_strobe(input logic [1:0] size);
        logic [3:0] s;
        case (size)
            2'b00:   s = STRB_B;
            2'b01:   s = STRB_H;
            2'b10:   s = STRB_W;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exu_lsu_ost_if.sv
// ---------------------------------------------------------------------------
// exu_lsu_ost_if
// Data-memory request/response channel of the load/store unit.
//   master : the LSU (drives request, accepts response)
//   slave  : the memory side
// Request : req_vld/req_rdy, req_addr, req_st, req_data, req_strobe
// Response: rsp_vld/rsp_rdy, rsp_data (raw aligned word)
// ---------------------------------------------------------------------------
interface exu_lsu_ost_if #(
    parameter int XLEN = 32
);
    logic              req_vld;
    logic              req_rdy;
    logic [XLEN-1:0]   req_addr;
    logic              req_st;
    logic [XLEN-1:0]   req_data;
    logic [XLEN/8-1:0] req_strobe;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [XLEN-1:0]   rsp_data;

    modport master (
        output req_vld, req_addr, req_st, req_data, req_strobe, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_data
    );

    modport slave (
        input  req_vld, req_addr, req_st, req_data, req_strobe, rsp_rdy,
        output req_rdy, rsp_vld, rsp_data
    );
endinterface

// File: rtl/exu_lsu_ost_fifo.sv
// ---------------------------------------------------------------------------
// lsu_ost_fifo
// Synchronous in-order FIFO tracking outstanding LSU requests.
// Ports: clk, rst_n (async active-low), push/din, pop/dout, count, full, empty.
// A push while full and a pop while empty are ignored.
// ---------------------------------------------------------------------------
module lsu_ost_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Explicit wrap keeps non-power-of-two-safe behaviour and DEPTH=1 working.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Status flags and qualified push/pop.
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == '0);
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        count     = count_r;
        dout      = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/exu_lsu_ost.sv
// ---------------------------------------------------------------------------
// exu_lsu_ost
// Execute-stage load/store unit with up to OST_DEPTH requests in flight.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   sel, inst           dispatch: current instruction is a load/store
//   issue               instruction accepted (handshake or misalign retire)
//   lsu                 memory request/response channel (exu_lsu_ost_if.master)
//   gpr_ra1/2, gpr_rd1/2  register read port
//   gpr_wen/wa/wd       load writeback
//   done, misalign, busy  completion pulse, misalign pulse, FIFO non-empty
// Optional feature: define LDST_MISALIGN_CHK_EN to retire misaligned
// half/word accesses locally with a misalign pulse instead of issuing them.
// ---------------------------------------------------------------------------
module exu_lsu_ost
    import exu_lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int GPR_AW    = 5,
    parameter int OST_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [31:0]       inst,
    output logic              issue,
    exu_lsu_ost_if.master     lsu,
    output logic [GPR_AW-1:0] gpr_ra1,
    output logic [GPR_AW-1:0] gpr_ra2,
    input  logic [XLEN-1:0]   gpr_rd1,
    input  logic [XLEN-1:0]   gpr_rd2,
    output logic              gpr_wen,
    output logic [GPR_AW-1:0] gpr_wa,
    output logic [XLEN-1:0]   gpr_wd,
    output logic              done,
    output logic              misalign,
    output logic              busy
);
    localparam int SB_W = XLEN / 8;
    localparam int CW   = $clog2(OST_DEPTH + 1);
    localparam int EW   = $bits(lsu_ost_t);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            is_ld_s;
    logic            is_st_s;
    logic [11:0]     imm12_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] addr_s;
    logic [1:0]      lo_s;
    logic            mis_s;
    logic            req_vld_s;
    logic            push_s;
    logic            pop_s;
    lsu_ost_t        push_entry_s;
    lsu_ost_t        head_s;
    logic [EW-1:0]   head_bits_s;
    logic [CW-1:0]   count_s;
    logic            full_s;
    logic            empty_s;
    logic [XLEN-1:0] shifted_s;

    // Decode, register read addresses and effective address.
    always_comb begin
        opcode_s = inst[6:0];
        funct3_s = inst[14:12];
        is_ld_s  = (opcode_s == OPC_LOAD);
        is_st_s  = (opcode_s == OPC_STORE);
        gpr_ra1  = GPR_AW'(inst[19:15]);
        if (is_st_s) begin
            gpr_ra2 = GPR_AW'(inst[24:20]);
            imm12_s = s_imm_decode(inst);
        end else begin
            gpr_ra2 = '0;
            imm12_s = i_imm_decode(inst);
        end
        imm_s  = {{(XLEN-12){imm12_s[11]}}, imm12_s};
        addr_s = gpr_rd1 + imm_s;
        lo_s   = addr_s[1:0];
    end

    // Misalignment check: half needs lo[0]=0, word needs lo=0.
    always_comb begin
`ifdef LDST_MISALIGN_CHK_EN
        mis_s = ((funct3_s[1:0] == 2'b01) & lo_s[0]) |
                ((funct3_s[1:0] == 2'b10) & (lo_s != 2'b00));
`else
        mis_s = 1'b0;
`endif
    end

    // Request channel, lane alignment of store data/strobe, FIFO push entry.
    // req_vld is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        req_vld_s      = rst_n & sel & ~full_s & ~mis_s;
        lsu.req_vld    = req_vld_s;
        lsu.req_addr   = addr_s;
        lsu.req_st     = is_st_s;
        lsu.req_data   = gpr_rd2 << {lo_s, 3'b000};
        lsu.req_strobe = SB_W'({{SB_W{1'b0}}, base_strobe(funct3_s[1:0])} << lo_s);
        push_s         = req_vld_s & lsu.req_rdy;
        misalign       = rst_n & sel & mis_s;
        issue          = push_s | misalign;
        push_entry_s   = '{is_ld: is_ld_s, funct3: funct3_s, rd: inst[11:7], lo: lo_s};
    end

    lsu_ost_fifo #(
        .W     (EW),
        .DEPTH (OST_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (push_entry_s),
        .pop   (pop_s),
        .dout  (head_bits_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Response handshake, load data extraction and writeback.
    always_comb begin
        head_s      = lsu_ost_t'(head_bits_s);
        lsu.rsp_rdy = ~empty_s;
        pop_s       = lsu.rsp_vld & ~empty_s;
        done        = pop_s;
        busy        = (count_s != '0);
        gpr_wen     = pop_s & head_s.is_ld;
        gpr_wa      = GPR_AW'(head_s.rd);
        shifted_s   = lsu.rsp_data >> {head_s.lo, 3'b000};
        case (head_s.funct3)
            LB:      gpr_wd = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
            LH:      gpr_wd = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            LBU:     gpr_wd = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
            LHU:     gpr_wd = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            default: gpr_wd = shifted_s;
        endcase
    end
endmodule

// File: tb/tb_exu_lsu_ost.sv
module tb_exu_lsu_ost;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [31:0] inst;
    logic        issue;
    logic [4:0]  gpr_ra1, gpr_ra2, gpr_wa;
    logic [31:0] gpr_rd1, gpr_rd2, gpr_wd;
    logic        gpr_wen, done, misalign, busy;

    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       is_ld;
        bit [2:0] f3;
        bit [4:0] rd;
        bit [1:0] lo;
    } exp_t;
    exp_t q[$];

    exu_lsu_ost_if #(.XLEN(XLEN)) bus ();

    exu_lsu_ost #(.XLEN(XLEN), .GPR_AW(5), .OST_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .inst     (inst),
        .issue    (issue),
        .lsu      (bus),
        .gpr_ra1  (gpr_ra1),
        .gpr_ra2  (gpr_ra2),
        .gpr_rd1  (gpr_rd1),
        .gpr_rd2  (gpr_rd2),
        .gpr_wen  (gpr_wen),
        .gpr_wa   (gpr_wa),
        .gpr_wd   (gpr_wd),
        .done     (done),
        .misalign (misalign),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign gpr_rd1 = (gpr_ra1 == 5'd0) ? 32'd0 : regs[gpr_ra1];
    assign gpr_rd2 = (gpr_ra2 == 5'd0) ? 32'd0 : regs[gpr_ra2];

    function automatic logic [31:0] rval(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    function automatic logic [31:0] enc_ld(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_st(input logic [2:0] f3, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    // Load result from the raw word: pick the addressed bytes, then extend.
    function automatic logic [31:0] load_value(input logic [31:0] raw, input logic [2:0] f3,
                                               input logic [1:0] lo);
        longint unsigned sh;
        longint v;
        sh = raw >> (8 * lo);
        case (f3)
            3'b000: begin v = longint'(sh % 256);   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = longint'(sh % 65536); if (v >= 32768) v = v - 65536; end
            3'b100: v = longint'(sh % 256);
            3'b101: v = longint'(sh % 65536);
            default: v = longint'(sh);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lo);
        int n;
        int m;
        n = 1 << f3[1:0];
        m = ((1 << n) - 1) << lo;
        return m[3:0];
    endfunction

    function automatic bit exp_mis(input logic [2:0] f3, input logic [1:0] lo);
`ifdef LDST_MISALIGN_CHK_EN
        if (f3[1:0] == 2'b01) return (lo % 2) != 0;
        if (f3[1:0] == 2'b10) return lo != 2'd0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Present one load/store; stall req_rdy for 'stall' cycles first.
    task automatic issue_one(input bit st, input logic [2:0] f3, input logic [4:0] rd_rs2,
                             input logic [4:0] rs1, input logic [11:0] imm, input int stall,
                             output bit was_mis);
        logic [31:0] addr;
        logic [1:0]  lo;
        exp_t        e;
        addr    = rval(rs1) + {{20{imm[11]}}, imm};
        lo      = addr[1:0];
        was_mis = exp_mis(f3, lo);
        sel     = 1'b1;
        inst    = st ? enc_st(f3, rd_rs2, rs1, imm) : enc_ld(f3, rd_rs2, rs1, imm);
        if (was_mis) begin
            settle();
            chk("mis_req_vld", bus.req_vld, 32'd0);
            chk("mis_issue", issue, 32'd1);
            chk("mis_pulse", misalign, 32'd1);
            chk("mis_done", done, 32'd0);
            step();
        end else begin
            for (int i = 0; i < stall; i++) begin
                bus.req_rdy = 1'b0;
                settle();
                chk("stall_req_vld", bus.req_vld, 32'd1);
                chk("stall_issue", issue, 32'd0);
                step();
            end
            bus.req_rdy = 1'b1;
            settle();
            chk("req_vld", bus.req_vld, 32'd1);
            chk("issue", issue, 32'd1);
            chk("req_addr", bus.req_addr, addr);
            chk("req_st", bus.req_st, {31'd0, st});
            chk("misalign_idle", misalign, 32'd0);
            if (st) begin
                chk("req_strobe", bus.req_strobe, {28'd0, store_strobe(f3, lo)});
                chk("req_data", bus.req_data, rval(rd_rs2) << (8 * lo));
            end
            step();
            e.is_ld = !st;
            e.f3    = f3;
            e.rd    = rd_rs2;
            e.lo    = lo;
            q.push_back(e);
        end
        sel = 1'b0;
    endtask

    // Return the response for the queue head after 'delay' idle cycles.
    task automatic resp_one(input logic [31:0] raw, input int delay);
        exp_t e;
        for (int i = 0; i < delay; i++) begin
            settle();
            chk("rsp_wait_done", done, 32'd0);
            step();
        end
        e = q[0];
        bus.rsp_vld  = 1'b1;
        bus.rsp_data = raw;
        settle();
        chk("rsp_rdy", bus.rsp_rdy, 32'd1);
        chk("done", done, 32'd1);
        chk("gpr_wen", gpr_wen, {31'd0, e.is_ld});
        if (e.is_ld) begin
            chk("gpr_wa", gpr_wa, {27'd0, e.rd});
            chk("gpr_wd", gpr_wd, load_value(raw, e.f3, e.lo));
        end
        step();
        void'(q.pop_front());
        bus.rsp_vld = 1'b0;
    endtask

    initial begin
        bit          m;
        exp_t        e;
        logic [2:0]  f3;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] raw;
        bit          st;

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0]      = 32'd0;
        rst_n        = 1'b0;
        sel          = 1'b1;
        inst         = enc_st(3'b010, 5'd2, 5'd1, 12'd0);
        bus.req_rdy  = 1'b1;
        bus.rsp_vld  = 1'b0;
        bus.rsp_data = 32'd0;
        #12;
        chk("rst_req_vld", bus.req_vld, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_rsp_rdy", bus.rsp_rdy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_gpr_wen", gpr_wen, 32'd0);
        chk("rst_misalign", misalign, 32'd0);
        step();
        rst_n = 1'b1;
        sel   = 1'b0;
        step();

        // SW 0xDEADBEEF to 0x100, response three cycles later
        regs[1] = 32'h0000_0100;
        regs[2] = 32'hDEAD_BEEF;
        issue_one(1'b1, 3'b010, 5'd2, 5'd1, 12'd0, 0, m);
        settle();
        chk("sw_busy", busy, 32'd1);
        step();
        resp_one(32'h0, 2);
        settle();
        chk("sw_done_once", done, 32'd0);
        chk("sw_busy_clear", busy, 32'd0);
        step();

        // LB / LBU at 0x103
        regs[3] = 32'h0000_0100;
        issue_one(1'b0, 3'b000, 5'd5, 5'd3, 12'd3, 0, m);
        resp_one(32'h80FF_FF00, 1);
        issue_one(1'b0, 3'b100, 5'd5, 5'd3, 12'd3, 1, m);
        resp_one(32'h80FF_FF00, 0);

        // SH 0x1234 at 0x102
        regs[4] = 32'h0000_1234;
        issue_one(1'b1, 3'b001, 5'd4, 5'd1, 12'd2, 0, m);
        resp_one(32'h0, 0);

        // Load to x0 still writes back
        issue_one(1'b0, 3'b010, 5'd0, 5'd1, 12'd4, 0, m);
        resp_one(32'h1357_9BDF, 0);

        // Three back-to-back loads with responses withheld
        issue_one(1'b0, 3'b010, 5'd6, 5'd1, 12'd0, 0, m);
        issue_one(1'b0, 3'b001, 5'd7, 5'd1, 12'd6, 0, m);
        sel  = 1'b1;
        inst = enc_ld(3'b000, 5'd8, 5'd1, 12'd9);
        settle();
        chk("full_req_vld", bus.req_vld, 32'd0);
        chk("full_issue", issue, 32'd0);
        chk("full_busy", busy, 32'd1);
        step();
        e = q[0];
        bus.rsp_vld  = 1'b1;
        bus.rsp_data = 32'hA1B2_C3D4;
        settle();
        chk("full_pop_no_push", bus.req_vld, 32'd0);
        chk("full_pop_done", done, 32'd1);
        chk("full_pop_wa", gpr_wa, {27'd0, e.rd});
        chk("full_pop_wd", gpr_wd, load_value(32'hA1B2_C3D4, e.f3, e.lo));
        step();
        void'(q.pop_front());
        bus.rsp_vld = 1'b0;
        issue_one(1'b0, 3'b000, 5'd8, 5'd1, 12'd9, 0, m);
        resp_one(32'h8765_4321, 0);
        resp_one(32'h0000_0080, 1);

        // Push and pop in the same cycle at occupancy one
        issue_one(1'b0, 3'b010, 5'd9, 5'd1, 12'd0, 0, m);
        for (int i = 0; i < 10; i++) begin
            e            = q[0];
            raw          = $urandom;
            rd           = 5'($urandom_range(1, 31));
            f3           = (i % 2 == 0) ? 3'b101 : 3'b000;
            bus.rsp_vld  = 1'b1;
            bus.rsp_data = raw;
            bus.req_rdy  = 1'b1;
            sel          = 1'b1;
            inst         = enc_ld(f3, rd, 5'd1, 12'(4 * i));
            settle();
            chk("pp_done", done, 32'd1);
            chk("pp_wa", gpr_wa, {27'd0, e.rd});
            chk("pp_wd", gpr_wd, load_value(raw, e.f3, e.lo));
            chk("pp_req_vld", bus.req_vld, 32'd1);
            chk("pp_busy", busy, 32'd1);
            step();
            void'(q.pop_front());
            e.is_ld = 1'b1;
            e.f3    = f3;
            e.rd    = rd;
            e.lo    = 2'd0;
            q.push_back(e);
        end
        sel         = 1'b0;
        bus.rsp_vld = 1'b0;
        resp_one($urandom, 0);

        // Misaligned word access at 0x101
`ifdef LDST_MISALIGN_CHK_EN
        issue_one(1'b0, 3'b010, 5'd10, 5'd1, 12'd1, 0, m);
        chk("mis_detected", {31'd0, m}, 32'd1);
        settle();
        chk("mis_one_cycle", misalign, 32'd0);
        chk("mis_no_push", busy, 32'd0);
        step();
`else
        issue_one(1'b0, 3'b010, 5'd10, 5'd1, 12'd1, 0, m);
        resp_one(32'hCAFE_F00D, 0);
`endif

        // Randomized loads and stores
        for (int i = 0; i < 40; i++) begin
            st  = bit'($urandom_range(0, 1));
            rs1 = 5'($urandom_range(1, 31));
            rs2 = 5'($urandom_range(0, 31));
            regs[rs1] = $urandom;
            if (rs2 != 5'd0) regs[rs2] = $urandom;
            if (st) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd4;
                if (f3 == 3'd4 && $urandom_range(0, 1) == 1) f3 = 3'd5;
            end
            issue_one(st, f3, rs2, rs1, 12'($urandom), $urandom_range(0, 2), m);
            if (!m) resp_one($urandom, $urandom_range(0, 3));
        end

        // Reset with two requests outstanding
        issue_one(1'b0, 3'b010, 5'd11, 5'd1, 12'd0, 0, m);
        issue_one(1'b0, 3'b010, 5'd12, 5'd1, 12'd4, 0, m);
        sel   = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_rsp_rdy", bus.rsp_rdy, 32'd0);
        chk("mid_rst_req_vld", bus.req_vld, 32'd0);
        q.delete();
        step();
        rst_n       = 1'b1;
        sel         = 1'b0;
        bus.rsp_vld = 1'b1;
        settle();
        chk("post_rst_rsp_rdy", bus.rsp_rdy, 32'd0);
        chk("post_rst_done", done, 32'd0);
        chk("post_rst_wen", gpr_wen, 32'd0);
        step();
        bus.rsp_vld = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
